// File: rtl/alu181_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial 74181 sequencer: state encoding and common S-codes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ALU_S_XOR is only XOR together with m=1; with m=0 the same code subtracts.
  localparam logic [3:0] ALU_S_ADD = 4'b1001;
  localparam logic [3:0] ALU_S_SUB = 4'b0110;
  localparam logic [3:0] ALU_S_AND = 4'b1011;
  localparam logic [3:0] ALU_S_OR  = 4'b1110;
  localparam logic [3:0] ALU_S_XOR = 4'b0110;

endpackage

// File: rtl/alu181_nibble_seq_alu74181.sv
// 4-bit 74181 slice with active-high data and active-low carry in/out.
// The eqv output is the open-collector A=B output: high when all F bits are 1.
module alu74181 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_cn_n,
  output logic [3:0] o_f,
  output logic       o_cout_n,
  output logic       o_eqv,
  output logic       o_g_n,
  output logic       o_p_n
);
  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_sum;

  // Per-bit propagate (x) and generate (y) terms; y implies x, so x + y matches the 74181 carry chain.
  assign w_x   = i_a | (i_b & {4{i_s[0]}}) | (~i_b & {4{i_s[1]}});
  assign w_y   = (i_a & ~i_b & {4{i_s[2]}}) | (i_a & i_b & {4{i_s[3]}});
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~i_cn_n};

  assign o_f      = i_m ? ~(w_x ^ w_y) : w_sum[3:0];
  assign o_cout_n = ~w_sum[4];
  assign o_eqv    = &o_f;
  assign o_p_n    = ~(&w_x);
  assign o_g_n    = ~(w_y[3] | (w_x[3] & w_y[2]) | (w_x[3] & w_x[2] & w_y[1]) |
                      (w_x[3] & w_x[2] & w_x[1] & w_y[0]));

endmodule

// File: rtl/alu181_nibble_seq.sv
// Nibble-serial W-bit ALU: one 74181 slice per clock, LSB nibble first, carry kept in a register.
// Build option `ALU_SEQ_EQV_EN adds rsp_eqv, the AND of the slice eqv output over all nibbles.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// RUN   | one nibble per clock through the slice
// DONE  | result held with rsp_valid=1 until rsp_ready
module alu181_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [3:0]   req_s,
  input  logic         req_m,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_f,
  output logic         rsp_carry,
  output logic         rsp_zero
`ifdef ALU_SEQ_EQV_EN
  ,
  output logic         rsp_eqv
`endif
);
  localparam int            CW       = $clog2(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  state_e        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_f;
  logic [3:0]    r_s;
  logic          r_m;
  logic          r_carry_n;
  logic [CW-1:0] r_cnt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_carry;
  logic          r_zero;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_f_nib;
  logic          w_cout_n;
  logic [W-1:0]  w_f_next;
`ifdef ALU_SEQ_EQV_EN
  logic          w_eqv;
  logic          r_eqv_acc;
`endif

  assign w_a_nib = r_a[4*r_cnt +: 4];
  assign w_b_nib = r_b[4*r_cnt +: 4];

  alu74181 u_slice (
    .i_a      (w_a_nib),
    .i_b      (w_b_nib),
    .i_s      (r_s),
    .i_m      (r_m),
    .i_cn_n   (r_carry_n),
    .o_f      (w_f_nib),
    .o_cout_n (w_cout_n),
`ifdef ALU_SEQ_EQV_EN
    .o_eqv    (w_eqv),
`else
    .o_eqv    (),
`endif
    .o_g_n    (),
    .o_p_n    ()
  );

  always_comb begin
    w_f_next = r_f;
    w_f_next[4*r_cnt +: 4] = w_f_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_m         <= 1'b0;
      r_carry_n   <= 1'b1;
      r_cnt       <= '0;
      r_f         <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
`ifdef ALU_SEQ_EQV_EN
      r_eqv_acc   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a         <= req_a;
            r_b         <= req_b;
            r_s         <= req_s;
            r_m         <= req_m;
            r_carry_n   <= ~req_cin;
            r_cnt       <= '0;
            r_f         <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_req_ready <= 1'b0;
            r_state     <= RUN;
`ifdef ALU_SEQ_EQV_EN
            r_eqv_acc   <= 1'b1;
`endif
          end
        end
        RUN: begin
          r_f       <= w_f_next;
          r_carry_n <= w_cout_n;
`ifdef ALU_SEQ_EQV_EN
          r_eqv_acc <= r_eqv_acc & w_eqv;
`endif
          if (r_cnt == CNT_LAST) begin
            r_carry     <= ~w_cout_n & ~r_m;
            r_zero      <= (w_f_next == '0);
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_f     = r_f;
  assign rsp_carry = r_carry;
  assign rsp_zero  = r_zero;
`ifdef ALU_SEQ_EQV_EN
  assign rsp_eqv   = r_eqv_acc;
`endif

endmodule
